// File: rtl/wb_stage_nlane_if.sv
// +--------------------------------------------------------------------------+
// | wb_stage_nlane_if : completion-in / writeback-out bundle of wb_stage_nlane |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface wb_stage_nlane_if #(
    parameter int LANES = 2,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int SID_W = 4
);
    logic [LANES-1:0]           wb_valid_i;
    logic [LANES*5-1:0]         wb_rd_i;
    logic [LANES*XLEN-1:0]      wb_value_i;
    logic [LANES*ILEN-1:0]      wb_inst_i;
    logic [LANES*(SID_W+1)-1:0] wb_sid_i;
    logic [LANES-1:0]           wb_redirect_i;
    logic [LANES*XLEN-1:0]      wb_redirect_pc_i;
    logic                       flush_i;

    logic [LANES-1:0]           wb_valid_o;
    logic [LANES*5-1:0]         wb_rd_o;
    logic [LANES*XLEN-1:0]      wb_value_o;
    logic [LANES*ILEN-1:0]      wb_inst_o;
    logic [LANES*(SID_W+1)-1:0] wb_sid_o;
    logic                       redirect_o;
    logic [XLEN-1:0]            redirect_pc_o;
    logic [SID_W:0]             redirect_sid_o;
    logic [2:0]                 wb_count_o;

    modport slave (
        input  wb_valid_i, wb_rd_i, wb_value_i, wb_inst_i, wb_sid_i,
               wb_redirect_i, wb_redirect_pc_i, flush_i,
        output wb_valid_o, wb_rd_o, wb_value_o, wb_inst_o, wb_sid_o,
               redirect_o, redirect_pc_o, redirect_sid_o, wb_count_o
    );

    modport master (
        output wb_valid_i, wb_rd_i, wb_value_i, wb_inst_i, wb_sid_i,
               wb_redirect_i, wb_redirect_pc_i, flush_i,
        input  wb_valid_o, wb_rd_o, wb_value_o, wb_inst_o, wb_sid_o,
               redirect_o, redirect_pc_o, redirect_sid_o, wb_count_o
    );
endinterface

`default_nettype wire

// File: rtl/wb_stage_nlane.sv
// +--------------------------------------------------------------------------+
// | wb_stage_nlane : N-lane writeback register with oldest-first redirect     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_stage_nlane #(
    parameter int LANES       = 2,
    parameter int XLEN        = 64,
    parameter int ILEN        = 32,
    parameter int SID_W       = 4,
    parameter int REDIRECT_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_stage_nlane_if.slave   bus
);
    localparam int SW     = SID_W + 1;
    localparam bit RDR_EN = (REDIRECT_EN != 0);

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        SQUASH = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [LANES-1:0]           valid_q;
    logic [2:0]                 count_q;
    logic                       redirect_q;
    logic [XLEN-1:0]            rpc_q;
    logic [SW-1:0]              rsid_q;
    logic [LANES-1:0][4:0]      rd_q;
    logic [LANES-1:0][XLEN-1:0] value_q;
    logic [LANES-1:0][ILEN-1:0] inst_q;
    logic [LANES-1:0][SW-1:0]   sid_q;

    logic [LANES-1:0][SW-1:0]   w_sid;
    logic [LANES-1:0][XLEN-1:0] w_pc;
    logic [LANES-1:0]           w_pre;
    logic [LANES-1:0]           w_keep;
    logic                       w_found;
    logic [SW-1:0]              w_best_sid;
    logic [XLEN-1:0]            w_best_pc;
    logic [2:0]                 w_cnt;

    // Wrap-aware age compare: a is older than b.
    function automatic logic older(input logic [SW-1:0] a, input logic [SW-1:0] b);
        if (a[SW-1] == b[SW-1]) return a[SW-2:0] < b[SW-2:0];
        else                    return a[SW-2:0] > b[SW-2:0];
    endfunction

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            assign w_sid[k] = bus.wb_sid_i[k*SW +: SW];
            assign w_pc[k]  = bus.wb_redirect_pc_i[k*XLEN +: XLEN];
        end
    endgenerate

    always_comb begin
        w_pre      = '0;
        w_keep     = '0;
        w_found    = 1'b0;
        w_best_sid = '0;
        w_best_pc  = '0;
        w_cnt      = '0;
        state_d    = state_q;

        // Filter against the pre-flush state, even in the flush cycle.
        for (int k = 0; k < LANES; k++) begin
            w_pre[k] = bus.wb_valid_i[k] &&
                       !(RDR_EN && state_q == SQUASH && older(rsid_q, w_sid[k]));
        end

        // Strict compare keeps the lowest index on an (illegal) age tie.
        for (int k = 0; k < LANES; k++) begin
            if (RDR_EN && w_pre[k] && bus.wb_redirect_i[k] &&
                (!w_found || older(w_sid[k], w_best_sid))) begin
                w_found    = 1'b1;
                w_best_sid = w_sid[k];
                w_best_pc  = w_pc[k];
            end
        end

        for (int k = 0; k < LANES; k++) begin
            w_keep[k] = w_pre[k] && !(w_found && older(w_best_sid, w_sid[k]));
            w_cnt     = w_cnt + 3'(w_keep[k]);
        end

        if (w_found)
            state_d = SQUASH;
        else if (state_q == SQUASH && bus.flush_i)
            state_d = NORMAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NORMAL;
            valid_q    <= '0;
            count_q    <= '0;
            redirect_q <= 1'b0;
            rpc_q      <= '0;
            rsid_q     <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= w_keep;
            count_q    <= w_cnt;
            redirect_q <= w_found;
            if (w_found) begin
                rpc_q  <= w_best_pc;
                rsid_q <= w_best_sid;
            end
        end
    end

    // Payload needs no reset; it is qualified by valid_q downstream.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (bus.wb_valid_i[k]) begin
                rd_q[k]    <= bus.wb_rd_i[k*5 +: 5];
                value_q[k] <= bus.wb_value_i[k*XLEN +: XLEN];
                inst_q[k]  <= bus.wb_inst_i[k*ILEN +: ILEN];
                sid_q[k]   <= w_sid[k];
            end
        end
    end

    assign bus.wb_valid_o     = valid_q;
    assign bus.wb_count_o     = count_q;
    assign bus.wb_rd_o        = rd_q;
    assign bus.wb_value_o     = value_q;
    assign bus.wb_inst_o      = inst_q;
    assign bus.wb_sid_o       = sid_q;
    assign bus.redirect_o     = redirect_q & RDR_EN;
    assign bus.redirect_pc_o  = rpc_q;
    assign bus.redirect_sid_o = rsid_q;
endmodule

`default_nettype wire

// File: tb/tb_wb_stage_nlane.sv
// +--------------------------------------------------------------------------+
// | tb_wb_stage_nlane : directed scoreboard bench for wb_stage_nlane          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_wb_stage_nlane;
    localparam int LANES = 2;
    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int SID_W = 4;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    wb_stage_nlane_if #(.LANES(LANES), .XLEN(XLEN), .ILEN(ILEN), .SID_W(SID_W)) bus ();

    wb_stage_nlane #(
        .LANES(LANES), .XLEN(XLEN), .ILEN(ILEN), .SID_W(SID_W), .REDIRECT_EN(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  v;
        logic [2:0]  cnt;
        logic        rdr;
        logic [63:0] pc;
        logic [4:0]  sid;
        logic [4:0]  rd0;
        logic [63:0] val0;
        logic [4:0]  rd1;
        logic [63:0] val1;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.wb_valid_i       = '0;
        bus.wb_rd_i          = '0;
        bus.wb_value_i       = '0;
        bus.wb_inst_i        = '0;
        bus.wb_sid_i         = '0;
        bus.wb_redirect_i    = '0;
        bus.wb_redirect_pc_i = '0;
        bus.flush_i          = 1'b0;
    endtask

    task automatic set_lane(input int k, input logic [4:0] rd, input logic [63:0] val,
                            input logic [4:0] sid, input logic rdr, input logic [63:0] pc);
        bus.wb_valid_i[k]                   = 1'b1;
        bus.wb_rd_i[k*5 +: 5]               = rd;
        bus.wb_value_i[k*XLEN +: XLEN]      = val;
        bus.wb_inst_i[k*ILEN +: ILEN]       = 32'h13 + 32'(k);
        bus.wb_sid_i[k*5 +: 5]              = sid;
        bus.wb_redirect_i[k]                = rdr;
        bus.wb_redirect_pc_i[k*XLEN +: XLEN] = pc;
    endtask

    task automatic push(input logic [1:0] v, input logic [2:0] cnt, input logic rdr,
                        input logic [63:0] pc, input logic [4:0] sid,
                        input logic [4:0] rd0, input logic [63:0] val0,
                        input logic [4:0] rd1, input logic [63:0] val1);
        exp_t e;
        e.v = v; e.cnt = cnt; e.rdr = rdr; e.pc = pc; e.sid = sid;
        e.rd0 = rd0; e.val0 = val0; e.rd1 = rd1; e.val1 = val1;
        sb.push_back(e);
    endtask

    // Clock the driven inputs through, then compare against the oldest expectation.
    task automatic step(input string tag, input logic fl);
        exp_t e;
        bus.flush_i = fl;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".valid"},   64'(bus.wb_valid_o),     64'(e.v));
        chk({tag, ".count"},   64'(bus.wb_count_o),     64'(e.cnt));
        chk({tag, ".redir"},   64'(bus.redirect_o),     64'(e.rdr));
        chk({tag, ".rpc"},     bus.redirect_pc_o,       e.pc);
        chk({tag, ".rsid"},    64'(bus.redirect_sid_o), 64'(e.sid));
        if (e.v[0]) begin
            chk({tag, ".rd0"},  64'(bus.wb_rd_o[4:0]),   64'(e.rd0));
            chk({tag, ".val0"}, bus.wb_value_o[63:0],    e.val0);
        end
        if (e.v[1]) begin
            chk({tag, ".rd1"},  64'(bus.wb_rd_o[9:5]),   64'(e.rd1));
            chk({tag, ".val1"}, bus.wb_value_o[127:64],  e.val1);
        end
        clear_inputs();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, 64'(bus.wb_valid_o),     64'd0);
        chk({tag, ".count"}, 64'(bus.wb_count_o),     64'd0);
        chk({tag, ".redir"}, 64'(bus.redirect_o),     64'd0);
        chk({tag, ".rpc"},   bus.redirect_pc_o,       64'd0);
        chk({tag, ".rsid"},  64'(bus.redirect_sid_o), 64'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;

        // Single lane writeback
        set_lane(0, 5'd5, 64'hDEAD, 5'd3, 1'b0, 64'h0);
        push(2'b01, 3'd1, 1'b0, 64'h0, 5'd0, 5'd5, 64'hDEAD, 5'd0, 64'h0);
        step("t1", 1'b0);

        // Lane0 redirects, older lane1 kept
        set_lane(0, 5'd1, 64'h11, 5'd6, 1'b1, 64'h8000_0100);
        set_lane(1, 5'd2, 64'h22, 5'd4, 1'b0, 64'h0);
        push(2'b11, 3'd2, 1'b1, 64'h8000_0100, 5'd6, 5'd1, 64'h11, 5'd2, 64'h22);
        step("t2", 1'b0);

        // SQUASH: younger dropped, redirect pulse is single-cycle
        set_lane(0, 5'd3, 64'h33, 5'd7, 1'b0, 64'h0);
        push(2'b00, 3'd0, 1'b0, 64'h8000_0100, 5'd6, 5'd0, 64'h0, 5'd0, 64'h0);
        step("t5a", 1'b0);

        // SQUASH: older lane re-redirects
        set_lane(0, 5'd4, 64'h44, 5'd5, 1'b1, 64'h300);
        push(2'b01, 3'd1, 1'b1, 64'h300, 5'd5, 5'd4, 64'h44, 5'd0, 64'h0);
        step("t5b", 1'b0);

        push(2'b00, 3'd0, 1'b0, 64'h300, 5'd5, 5'd0, 64'h0, 5'd0, 64'h0);
        step("t5flush", 1'b1);

        set_lane(1, 5'd9, 64'h99, 5'd9, 1'b0, 64'h0);
        push(2'b10, 3'd1, 1'b0, 64'h300, 5'd5, 5'd0, 64'h0, 5'd9, 64'h99);
        step("t5c", 1'b0);

        // Both redirect: older lane1 wins, lane0 dropped
        set_lane(0, 5'd6, 64'h66, 5'd2, 1'b1, 64'h1000);
        set_lane(1, 5'd7, 64'h77, 5'd1, 1'b1, 64'h2000);
        push(2'b10, 3'd1, 1'b1, 64'h2000, 5'd1, 5'd0, 64'h0, 5'd7, 64'h77);
        step("t3", 1'b0);

        // Flush cycle still filters with the SQUASH state
        set_lane(0, 5'd12, 64'hCC, 5'd3, 1'b0, 64'h0);
        push(2'b00, 3'd0, 1'b0, 64'h2000, 5'd1, 5'd0, 64'h0, 5'd0, 64'h0);
        step("flushfilt", 1'b1);

        // Wrap-bit ordering
        set_lane(0, 5'd8, 64'h88, 5'b1_0001, 1'b1, 64'h4000);
        set_lane(1, 5'd10, 64'hAA, 5'b0_1110, 1'b0, 64'h0);
        push(2'b11, 3'd2, 1'b1, 64'h4000, 5'b1_0001, 5'd8, 64'h88, 5'd10, 64'hAA);
        step("t4", 1'b0);

        push(2'b00, 3'd0, 1'b0, 64'h4000, 5'b1_0001, 5'd0, 64'h0, 5'd0, 64'h0);
        step("flush2", 1'b1);

        // Flush together with a NORMAL-mode winner: redirect wins
        set_lane(0, 5'd13, 64'hD0, 5'd2, 1'b1, 64'h5000);
        push(2'b01, 3'd1, 1'b1, 64'h5000, 5'd2, 5'd13, 64'hD0, 5'd0, 64'h0);
        step("flushwin", 1'b1);

        set_lane(0, 5'd14, 64'hE0, 5'd3, 1'b0, 64'h0);
        push(2'b00, 3'd0, 1'b0, 64'h5000, 5'd2, 5'd0, 64'h0, 5'd0, 64'h0);
        step("stillsq", 1'b0);

        // Reset mid-SQUASH with valid inputs applied
        set_lane(0, 5'd15, 64'hF0, 5'd1, 1'b1, 64'h6000);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_async");
        @(posedge clk);
        #1;
        chk_reset("rst_hold");
        #2;
        rst_n = 1'b1;
        clear_inputs();

        set_lane(0, 5'd11, 64'hBB, 5'd7, 1'b0, 64'h0);
        push(2'b01, 3'd1, 1'b0, 64'h0, 5'd0, 5'd11, 64'hBB, 5'd0, 64'h0);
        step("t6", 1'b0);

        push(2'b00, 3'd0, 1'b0, 64'h0, 5'd0, 5'd0, 64'h0, 5'd0, 64'h0);
        step("idle", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
